run_controller: RTL

Host-side sequencer for the single-cycle RISC-V core. It receives a program over a valid/ready stream and stores it in a 256-word buffer that drives the core's `mem_input` array. It holds the core in reset while loading, then runs, single-steps or halts the core through a clock-enable. It stops the core on `ebreak`, a host halt, a cycle limit or an illegal PC, and reports the halt cause and the count of retired instructions.

---
 rtl/run_ctrl_pkg.sv | 31 +++
 rtl/prog_buffer.sv | 46 ++++
 rtl/run_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the host-side run controller of the RISC-V core.
// Holds the FSM state encoding, halt causes and the PC legality helper.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      READY,
      RUN,
      STEP,
      HALTED
   } state_t;

   typedef enum logic [2:0] {
      HC_NONE   = 3'd0,
      HC_EBREAK = 3'd1,
      HC_HOST   = 3'd2,
      HC_LIMIT  = 3'd3,
      HC_STEP   = 3'd4,
      HC_BADPC  = 3'd5
   } halt_cause_t;

   localparam logic [31:0] EBREAK_INSTR  = 32'h0010_0073;
   localparam int          PC_LIMIT_BITS = 10;

   // A PC is legal only if word-aligned and inside the program buffer window.
   function automatic logic pc_is_bad(input logic [31:0] pc);
      return (|pc[31:PC_LIMIT_BITS]) || (|pc[1:0]);
   endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program buffer: MEM_DEPTH x 32 register array written sequentially from the load stream.
// Flags the accept that completes a program (explicit last word or buffer full).
module prog_buffer #(
   parameter int MEM_DEPTH = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en_i,
   input  logic                         wr_restart_i,
   input  logic [31:0]                  wr_data_i,
   input  logic                         wr_last_i,
   output logic [0:MEM_DEPTH-1][31:0]   mem_o,
   output logic                         wr_done_o
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   logic [IDX_W-1:0]               idx_q, idx_d, wr_addr;
   logic [0:MEM_DEPTH-1][31:0]     mem_q;

   // A new program always starts at word 0, whatever the index was left at.
   always_comb begin
      wr_addr   = wr_restart_i ? '0 : idx_q;
      idx_d     = idx_q;
      if (wr_en_i) begin
         idx_d = wr_addr + IDX_W'(1);
      end
      wr_done_o = wr_en_i && (wr_last_i || (wr_addr == IDX_W'(MEM_DEPTH - 1)));
   end

   // NOTE: this array is flops, not a RAM macro, so it can and must be cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         mem_q <= '0;
      end else begin
         idx_q <= idx_d;
         if (wr_en_i) begin
            mem_q[wr_addr] <= wr_data_i;
         end
      end
   end

   assign mem_o = mem_q;

endmodule

// File: rtl/run_controller.sv
// Host-side sequencer: loads a program into the buffer, then runs, steps or halts the core
// through core_en, tracking halt cause and retired-instruction count.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int LIMIT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_valid,
   input  logic [31:0]                  load_data,
   input  logic                         load_last,
   output logic                         load_ready,
   input  logic                         cmd_run,
   input  logic                         cmd_step,
   input  logic                         cmd_halt,
   input  logic [LIMIT_W-1:0]           cycle_limit,
   input  logic [31:0]                  core_pc,
   input  logic [31:0]                  core_instr,
   output logic [0:MEM_DEPTH-1][31:0]   prog_mem,
   output logic                         core_rst,
   output logic                         core_en,
   output logic                         busy,
   output logic [2:0]                   halt_cause,
   output logic [31:0]                  retired
);

   state_t             state_q, state_d;
   halt_cause_t        cause_q, cause_d;
   logic               busy_q, busy_d;
   logic [31:0]        retired_q, retired_d;
   logic [LIMIT_W-1:0] run_cnt_q, run_cnt_d;

   logic accept, restart, wr_done;
   logic bad_pc, is_ebreak, limit_hit;

   assign accept    = load_valid && load_ready;
   assign restart   = accept && ((state_q == IDLE) || (state_q == HALTED));
   assign bad_pc    = pc_is_bad(core_pc);
   assign is_ebreak = (core_instr == EBREAK_INSTR);
   // Limit is per run: counted from entry into RUN/STEP, not from the last load.
   assign limit_hit = (cycle_limit != '0) &&
                      ((LIMIT_W+1)'(run_cnt_q) + (LIMIT_W+1)'(1) == (LIMIT_W+1)'(cycle_limit));

   prog_buffer #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_prog_buffer (
      .clk          (clk),
      .rst          (rst),
      .wr_en_i      (accept),
      .wr_restart_i (restart),
      .wr_data_i    (load_data),
      .wr_last_i    (load_last),
      .mem_o        (prog_mem),
      .wr_done_o    (wr_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cause_q   <= HC_NONE;
         busy_q    <= 1'b0;
         retired_q <= '0;
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         busy_q    <= busy_d;
         retired_q <= retired_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      load_ready = 1'b0;
      core_rst   = 1'b0;
      core_en    = 1'b0;
      unique case (state_q)
         IDLE, LOAD: begin
            load_ready = 1'b1;
            core_rst   = 1'b1;
         end
         READY:  core_rst   = 1'b1;
         RUN:    core_en    = !bad_pc && !is_ebreak && !cmd_halt;
         STEP:   core_en    = !bad_pc && !is_ebreak;
         HALTED: load_ready = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      retired_d = retired_q + 32'(core_en);
      run_cnt_d = run_cnt_q + LIMIT_W'(core_en);
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               retired_d = '0;
               cause_d   = HC_NONE;
               state_d   = wr_done ? READY : LOAD;
            end
         end
         LOAD: begin
            if (wr_done) state_d = READY;
         end
         READY, HALTED: begin
            // A word accepted in HALTED must not be lost, so loading wins over commands.
            if (restart) begin
               retired_d = '0;
               cause_d   = HC_NONE;
               state_d   = wr_done ? READY : LOAD;
            end else if (cmd_halt && (cmd_step || cmd_run)) begin
               cause_d = HC_HOST;
               state_d = HALTED;
            end else if (cmd_step) begin
               cause_d   = HC_NONE;
               run_cnt_d = '0;
               state_d   = STEP;
            end else if (cmd_run) begin
               cause_d   = HC_NONE;
               run_cnt_d = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (bad_pc) begin
               cause_d = HC_BADPC;
               state_d = HALTED;
            end else if (is_ebreak) begin
               cause_d = HC_EBREAK;
               state_d = HALTED;
            end else if (cmd_halt) begin
               cause_d = HC_HOST;
               state_d = HALTED;
            end else if (limit_hit) begin
               cause_d = HC_LIMIT;
               state_d = HALTED;
            end
         end
         STEP: begin
            state_d = HALTED;
            if (bad_pc)         cause_d = HC_BADPC;
            else if (is_ebreak) cause_d = HC_EBREAK;
            else                cause_d = HC_STEP;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN) || (state_d == STEP);
   end

   assign busy       = busy_q;
   assign halt_cause = cause_q;
   assign retired    = retired_q;

endmodule
